// File: rtl/req_demux4.sv
// req_demux4
//   Routes one load/store request at a time from a single initiator to one of
//   four targets (RAM, ROM, MMIO, spare). The target is picked by the address
//   bits addr[SEL_LSB+1:SEL_LSB]. The design forwards the request over a
//   valid/ready handshake, waits for that target's response and returns it as
//   a one-cycle pulse. A cycle counter turns a hung target into an error
//   response after TIMEOUT cycles. Setting TIMEOUT to 0 disables this.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_*             initiator request (valid/ready, addr, wdata, we, be)
//   o_rsp_*             response pulse (valid), read data, timeout error
//   o_t_req_valid       per-target request valid (one-hot or zero)
//   i_t_req_ready       per-target request ready
//   o_t_addr/wdata/we/be  registered payload shared by all targets
//   i_t_rsp_valid       per-target response valid
//   i_t_rsp_rdata       per-target read data, target k at [k*DATA_W +: DATA_W]
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a new request from the initiator
// ST_REQ   | presenting request to the selected target, awaiting ready
// ST_RSP   | request taken by target, awaiting its response
module req_demux4 #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int          SEL_LSB = 30,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    input  logic                  i_req_we,
    input  logic [DATA_W/8-1:0]   i_req_be,
    output logic                  o_rsp_valid,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [3:0]            o_t_req_valid,
    input  logic [3:0]            i_t_req_ready,
    output logic [ADDR_W-1:0]     o_t_addr,
    output logic [DATA_W-1:0]     o_t_wdata,
    output logic                  o_t_we,
    output logic [DATA_W/8-1:0]   o_t_be,
    input  logic [3:0]            i_t_rsp_valid,
    input  logic [4*DATA_W-1:0]   i_t_rsp_rdata
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]   rdata_sel;
    logic                timeout_hit;

    // Read data lane of the currently selected target.
    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < 4; k++) begin
            if (sel_q == 2'(k)) begin
                rdata_sel = i_t_rsp_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_VAL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        be_d        = be_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    sel_d   = i_req_addr[SEL_LSB+1:SEL_LSB];
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    we_d    = i_req_we;
                    be_d    = i_req_be;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CW'(1);
                // Only a response counts as completion, so a handshake in the
                // terminal cycle still loses to the timeout.
                if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else if (i_t_req_ready[sel_q]) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                cnt_d = cnt_q + CW'(1);
                // Completion takes priority over a timeout in the same cycle.
                if (i_t_rsp_valid[sel_q]) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : rdata_sel;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        o_t_req_valid = '0;
        if (state_q == ST_REQ) begin
            o_t_req_valid[sel_q] = 1'b1;
        end
    end

    // Ready is gated by reset so the initiator never sees it while in reset.
    assign o_req_ready = (state_q == ST_IDLE) && !i_rst;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_t_addr    = addr_q;
    assign o_t_wdata   = wdata_q;
    assign o_t_we      = we_q;
    assign o_t_be      = be_q;

endmodule

// File: tb/tb_req_demux4.sv
// Testbench for req_demux4. It drives randomized transactions, with the bench
// playing all four targets. Expected outputs for each cycle come from a
// transaction-level timing model.
module tb_req_demux4;

    localparam int TO = 8;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_req_valid;
    logic         o_req_ready;
    logic [31:0]  i_req_addr;
    logic [31:0]  i_req_wdata;
    logic         i_req_we;
    logic [3:0]   i_req_be;
    logic         o_rsp_valid;
    logic [31:0]  o_rsp_rdata;
    logic         o_rsp_err;
    logic [3:0]   o_t_req_valid;
    logic [3:0]   i_t_req_ready;
    logic [31:0]  o_t_addr;
    logic [31:0]  o_t_wdata;
    logic         o_t_we;
    logic [3:0]   o_t_be;
    logic [3:0]   i_t_rsp_valid;
    logic [127:0] i_t_rsp_rdata;

    req_demux4 #(
        .ADDR_W (32),
        .DATA_W (32),
        .SEL_LSB(30),
        .TIMEOUT(TO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .i_req_we     (i_req_we),
        .i_req_be     (i_req_be),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_t_req_valid(o_t_req_valid),
        .i_t_req_ready(i_t_req_ready),
        .o_t_addr     (o_t_addr),
        .o_t_wdata    (o_t_wdata),
        .o_t_we       (o_t_we),
        .o_t_be       (o_t_be),
        .i_t_rsp_valid(i_t_rsp_valid),
        .i_t_rsp_rdata(i_t_rsp_rdata)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err   = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Runs one transaction. Called and returns at a negedge: the call's
    // negedge is the accept cycle, the return's negedge is the response
    // pulse, so consecutive calls issue back-to-back requests.
    //   d        cycles the selected target withholds ready
    //   r        cycles between the handshake and the response
    //   sel_data read data the selected target returns
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] be, input int d, input int r,
                           input logic [31:0] sel_data, output int acc);
        int          sel;
        int          pulse_k;
        int          vend;
        logic        err_exp;
        logic [31:0] rd_exp;
        logic [68:0] pay_exp;
        logic [3:0]  tv_exp;

        sel     = int'(addr[31:30]);
        pay_exp = {addr, wdata, we, be};
        // Counter is 0 in the first REQ cycle (k=1), so in cycle k it reads
        // k-1. A handshake at count TO loses to the timeout, while a response
        // at count TO still wins.
        if (d < TO && d + r + 1 <= TO) begin
            err_exp = 1'b0;
            pulse_k = d + r + 3;
            vend    = d + 1;
            rd_exp  = we ? 32'h0 : sel_data;
        end else begin
            err_exp = 1'b1;
            pulse_k = TO + 2;
            vend    = (d < TO) ? d + 1 : TO + 1;
            rd_exp  = 32'h0;
        end

        i_req_valid   = 1'b1;
        i_req_addr    = addr;
        i_req_wdata   = wdata;
        i_req_we      = we;
        i_req_be      = be;
        i_t_req_ready = '0;
        i_t_rsp_valid = '0;
        acc = cyc;
        chk("req_ready_accept", o_req_ready, 1'b1);

        for (int k = 1; k <= pulse_k; k++) begin
            @(posedge i_clk);
            #1;
            // Scribble on the initiator inputs to prove the payload is held.
            i_req_valid = (k == pulse_k) ? 1'b0 : 1'($urandom_range(0, 1));
            i_req_addr  = $urandom;
            i_req_wdata = $urandom;
            i_req_we    = 1'($urandom_range(0, 1));
            i_req_be    = 4'($urandom);
            i_t_req_ready = 4'($urandom);
            i_t_req_ready[sel] = (k == d + 1) || (k > d + 1 && $urandom_range(0, 1) == 1);
            i_t_rsp_valid = 4'($urandom);
            i_t_rsp_valid[sel] = (k <= d + 1) ? 1'($urandom_range(0, 1)) : (k == d + r + 2);
            for (int j = 0; j < 4; j++) i_t_rsp_rdata[j*32 +: 32] = $urandom;
            if (k == d + r + 2) i_t_rsp_rdata[sel*32 +: 32] = sel_data;

            @(negedge i_clk);
            tv_exp = (k <= vend) ? (4'b0001 << sel) : 4'b0000;
            chk("t_req_valid", o_t_req_valid, tv_exp);
            if (k <= vend) chk("t_payload", {o_t_addr, o_t_wdata, o_t_we, o_t_be}, pay_exp);
            chk("rsp_valid", o_rsp_valid, k == pulse_k);
            chk("rsp_rdata", o_rsp_rdata, (k == pulse_k) ? rd_exp : last_rdata);
            chk("rsp_err", o_rsp_err, (k == pulse_k) ? err_exp : last_err);
            chk("req_ready", o_req_ready, k == pulse_k);
        end
        last_rdata = rd_exp;
        last_err   = err_exp;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_t_req_valid"}, o_t_req_valid, 4'b0);
        chk({tag, "_rsp_valid"}, o_rsp_valid, 1'b0);
        chk({tag, "_rsp_err"}, o_rsp_err, 1'b0);
        chk({tag, "_rsp_rdata"}, o_rsp_rdata, 32'h0);
        chk({tag, "_payload"}, {o_t_addr, o_t_wdata, o_t_we, o_t_be}, 69'h0);
    endtask

    // Reset lands in RSP together with a target response, which must be lost.
    task automatic reset_in_rsp();
        i_req_valid   = 1'b1;
        i_req_addr    = 32'h8000_0040;
        i_req_wdata   = 32'hA5A5_A5A5;
        i_req_we      = 1'b0;
        i_req_be      = 4'hF;
        i_t_req_ready = '0;
        i_t_rsp_valid = '0;
        chk("rst_accept_ready", o_req_ready, 1'b1);
        @(posedge i_clk); #1;
        i_req_valid   = 1'b0;
        i_t_req_ready = 4'b0100;
        @(negedge i_clk);
        chk("rst_t_req_valid", o_t_req_valid, 4'b0100);
        @(posedge i_clk); #1;
        i_t_req_ready = '0;
        i_rst         = 1'b1;
        i_t_rsp_valid = 4'b0100;
        i_t_rsp_rdata = {4{32'h5555_AAAA}};
        @(negedge i_clk);
        chk("rst_ready_low", o_req_ready, 1'b0);
        @(posedge i_clk); #1;
        i_t_rsp_valid = '0;
        @(negedge i_clk);
        chk("rst_ready_held", o_req_ready, 1'b0);
        check_reset_outputs("rst_mid");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready_after", o_req_ready, 1'b1);
        check_reset_outputs("rst_after");
        last_rdata = '0;
        last_err   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a3;
        i_rst         = 1'b1;
        i_req_valid   = 1'b0;
        i_req_addr    = '0;
        i_req_wdata   = '0;
        i_req_we      = 1'b0;
        i_req_be      = '0;
        i_t_req_ready = '0;
        i_t_rsp_valid = '0;
        i_t_rsp_rdata = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("init_ready_in_rst", o_req_ready, 1'b0);
        check_reset_outputs("init");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("init_ready_after", o_req_ready, 1'b1);

        // read to target 2, immediate ready and response
        run_txn(32'h8000_0010, 1'b0, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, a0);
        // write to target 0, ready delayed 5 cycles
        run_txn(32'h0000_0004, 1'b1, 32'h1234_5678, 4'b0011, 5, 0, 32'hFFFF_FFFF, a0);
        // back-to-back reads to targets 0, 1, 3
        run_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 0, 32'h1111_0000, a1);
        run_txn(32'h4000_0200, 1'b0, 32'h0, 4'hF, 0, 0, 32'h2222_0001, a2);
        run_txn(32'hC000_0300, 1'b0, 32'h0, 4'hF, 0, 0, 32'h3333_0003, a3);
        chk("b2b_gap_1", 32'(a2 - a1), 32'd3);
        chk("b2b_gap_2", 32'(a3 - a2), 32'd3);
        // target 3 never ready, then a normal request
        run_txn(32'hC000_0000, 1'b0, 32'h0, 4'hF, 1000, 0, 32'h0BAD_0BAD, a0);
        run_txn(32'h4000_0008, 1'b0, 32'h0, 4'hF, 1, 1, 32'h600D_600D, a0);
        // response timing at and just past the timeout boundary
        run_txn(32'h8000_0020, 1'b0, 32'h0, 4'hF, 3, TO - 4, 32'hB0B0_B0B0, a0);
        run_txn(32'h8000_0024, 1'b0, 32'h0, 4'hF, 3, TO - 3, 32'hC0C0_C0C0, a0);
        run_txn(32'h0000_0028, 1'b0, 32'h0, 4'hF, TO, 0, 32'hD0D0_D0D0, a0);
        // target 2 in RSP with stray responses from the others
        run_txn(32'h8000_0030, 1'b0, 32'h0, 4'hF, 0, 3, 32'hCAFE_F00D, a0);
        reset_in_rsp();
        run_txn(32'h4000_0050, 1'b0, 32'h0, 4'hF, 0, 0, 32'h7777_8888, a0);

        for (int t = 0; t < 150; t++) begin
            int d, r;
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2);
            r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
            run_txn($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), d, r, $urandom, a0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
